// File: rtl/sar_timer_gen_if.sv
// rtl/sar_timer_gen_if.sv - sequencer/consumer bundle for the SAR settle timer
interface sar_timer_gen_if #(
    parameter int WIDTH = 8,
    parameter int TMR_W = 7
);
    logic [1:0]       StateP;
    logic [WIDTH-1:0] SAROut;
    logic             Inc;
    logic             Dcr;
    logic             Ack;
    logic [WIDTH-1:0] DataOut;
    logic [WIDTH-1:0] SAROutI;
    logic [WIDTH-1:0] SAROutD;
    logic [WIDTH-1:0] SAROutC;
    logic [TMR_W-1:0] TimerOut;
    logic             Ready;
    logic             Busy;

    modport master (
        output StateP, SAROut, Inc, Dcr, Ack,
        input  DataOut, SAROutI, SAROutD, SAROutC, TimerOut, Ready, Busy
    );

    modport slave (
        input  StateP, SAROut, Inc, Dcr, Ack,
        output DataOut, SAROutI, SAROutD, SAROutC, TimerOut, Ready, Busy
    );
endinterface

// File: rtl/sar_timer_gen.sv
// rtl/sar_timer_gen.sv - SAR code tracker with saturating step and quiet-time settle detect
module sar_timer_gen #(
    parameter int WIDTH   = 8,
    parameter int TMR_W   = 7,
    parameter int STEP    = 1,
    parameter int TIMEOUT = 127
) (
    input  logic           ClockT,
    input  logic           Reset,
    sar_timer_gen_if.slave bus
);

    localparam logic [WIDTH:0]   MAX_CODE = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [TMR_W-1:0] TMO      = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMO_M1   = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] code, code_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             ready_n;
    logic [WIDTH-1:0] dout_n;
    logic [TMR_W-1:0] tout_n;

    logic [WIDTH:0]   code_up;
    logic [WIDTH:0]   code_dn;
    logic [WIDTH-1:0] code_inc;
    logic [WIDTH-1:0] code_dec;

    logic idle_req;
    logic track_req;
    logic step_req;

    // One extra bit catches overflow above the top code and borrow below zero
    assign code_up  = {1'b0, code} + STEP_X;
    assign code_dn  = {1'b0, code} - STEP_X;
    assign code_inc = (code_up > MAX_CODE) ? {WIDTH{1'b1}} : code_up[WIDTH-1:0];
    assign code_dec = code_dn[WIDTH] ? {WIDTH{1'b0}} : code_dn[WIDTH-1:0];

    assign idle_req  = (bus.StateP == 2'b00);
    assign track_req = (bus.StateP == 2'b01);
    assign step_req  = bus.Inc ^ bus.Dcr;

    assign bus.Busy = (state == S_TRACK);

    always_comb begin
        state_n = state;
        code_n  = code;
        timer_n = timer;
        ready_n = bus.Ready;
        dout_n  = bus.DataOut;
        tout_n  = bus.TimerOut;
        case (state)
            S_IDLE: begin
                code_n  = bus.SAROut;
                timer_n = '0;
                if (track_req) begin
                    state_n = S_TRACK;
                end
            end
            S_TRACK: begin
                if (idle_req) begin
                    state_n = S_IDLE;
                end else begin
                    // HOLD modes fall through with code and timer untouched
                    if (track_req) begin
                        if (step_req) begin
                            code_n  = bus.Inc ? code_inc : code_dec;
                            timer_n = '0;
                        end else if (timer == TMO_M1) begin
                            timer_n = TMO;
                            dout_n  = code;
                            ready_n = 1'b1;
                            state_n = S_DONE;
                        end else begin
                            timer_n = timer + TMR_W'(1);
                        end
                    end
                    tout_n = timer_n;
                end
            end
            S_DONE: begin
                if (idle_req) begin
                    ready_n = 1'b0;
                    state_n = S_IDLE;
                end else if (bus.Ack) begin
                    ready_n = 1'b0;
                    timer_n = '0;
                    state_n = S_TRACK;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ClockT or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            code         <= '0;
            timer        <= '0;
            bus.Ready    <= 1'b0;
            bus.DataOut  <= '0;
            bus.TimerOut <= '0;
            bus.SAROutI  <= WIDTH'(STEP);
            bus.SAROutD  <= '0;
            bus.SAROutC  <= '1;
        end else begin
            state        <= state_n;
            code         <= code_n;
            timer        <= timer_n;
            bus.Ready    <= ready_n;
            bus.DataOut  <= dout_n;
            bus.TimerOut <= tout_n;
            bus.SAROutI  <= code_inc;
            bus.SAROutD  <= code_dec;
            bus.SAROutC  <= ~code;
        end
    end

endmodule

// File: tb/tb_sar_timer_gen.sv
// tb/tb_sar_timer_gen.sv - bench for sar_timer_gen (STEP=1 and STEP=4, TIMEOUT=4)
module tb_sar_timer_gen;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    sar_timer_gen_if #(.WIDTH(8), .TMR_W(7)) ia ();
    sar_timer_gen_if #(.WIDTH(8), .TMR_W(7)) ib ();

    sar_timer_gen #(.WIDTH(8), .TMR_W(7), .STEP(1), .TIMEOUT(4)) dut_a (
        .ClockT (clk),
        .Reset  (rst),
        .bus    (ia)
    );

    sar_timer_gen #(.WIDTH(8), .TMR_W(7), .STEP(4), .TIMEOUT(4)) dut_b (
        .ClockT (clk),
        .Reset  (rst),
        .bus    (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] statep;
        logic [7:0] sarout;
        logic       inc;
        logic       dcr;
        logic       ack;
        logic [7:0] e_c;
        logic [7:0] e_i;
        logic       e_rdy;
        logic       e_busy;
        logic [6:0] e_tmr;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl [22];
    vec_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [1:0] sp, input logic [7:0] so,
                         input logic inc, input logic dcr, input logic ack);
        if (!sel) begin
            ia.StateP = sp; ia.SAROut = so; ia.Inc = inc; ia.Dcr = dcr; ia.Ack = ack;
        end else begin
            ib.StateP = sp; ib.SAROut = so; ib.Inc = inc; ib.Dcr = dcr; ib.Ack = ack;
        end
    endtask

    task automatic step(input bit sel, input logic [1:0] sp, input logic [7:0] so,
                        input logic inc, input logic dcr, input logic ack);
        @(negedge clk);
        drive(sel, sp, so, inc, dcr, ack);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        tests = 0;
        fails = 0;

        //          sp     sarout inc dcr ack  sarc   sari   rdy busy tmr    dout
        tbl[0]  = '{2'b00, 8'h80, 0, 0, 0, 8'hFF, 8'h01, 0, 0, 7'd0, 8'h00};
        tbl[1]  = '{2'b01, 8'h80, 0, 0, 0, 8'h7F, 8'h81, 0, 1, 7'd0, 8'h00};
        tbl[2]  = '{2'b01, 8'h80, 1, 0, 0, 8'h7F, 8'h81, 0, 1, 7'd0, 8'h00};
        tbl[3]  = '{2'b01, 8'h80, 1, 0, 0, 8'h7E, 8'h82, 0, 1, 7'd0, 8'h00};
        tbl[4]  = '{2'b01, 8'h80, 1, 0, 0, 8'h7D, 8'h83, 0, 1, 7'd0, 8'h00};
        tbl[5]  = '{2'b01, 8'h80, 0, 0, 0, 8'h7C, 8'h84, 0, 1, 7'd1, 8'h00};
        tbl[6]  = '{2'b01, 8'h80, 0, 0, 0, 8'h7C, 8'h84, 0, 1, 7'd2, 8'h00};
        tbl[7]  = '{2'b01, 8'h80, 0, 0, 0, 8'h7C, 8'h84, 0, 1, 7'd3, 8'h00};
        tbl[8]  = '{2'b01, 8'h80, 0, 0, 0, 8'h7C, 8'h84, 1, 0, 7'd4, 8'h83};
        tbl[9]  = '{2'b01, 8'h80, 1, 0, 0, 8'h7C, 8'h84, 1, 0, 7'd4, 8'h83};
        tbl[10] = '{2'b01, 8'h80, 0, 0, 1, 8'h7C, 8'h84, 0, 1, 7'd4, 8'h83};
        tbl[11] = '{2'b01, 8'h80, 0, 1, 0, 8'h7C, 8'h84, 0, 1, 7'd0, 8'h83};
        tbl[12] = '{2'b01, 8'h80, 1, 1, 0, 8'h7D, 8'h83, 0, 1, 7'd1, 8'h83};
        tbl[13] = '{2'b01, 8'h80, 1, 1, 0, 8'h7D, 8'h83, 0, 1, 7'd2, 8'h83};
        tbl[14] = '{2'b10, 8'h80, 0, 0, 0, 8'h7D, 8'h83, 0, 1, 7'd2, 8'h83};
        tbl[15] = '{2'b11, 8'h80, 1, 0, 0, 8'h7D, 8'h83, 0, 1, 7'd2, 8'h83};
        tbl[16] = '{2'b01, 8'h80, 1, 1, 0, 8'h7D, 8'h83, 0, 1, 7'd3, 8'h83};
        tbl[17] = '{2'b01, 8'h80, 0, 0, 0, 8'h7D, 8'h83, 1, 0, 7'd4, 8'h82};
        tbl[18] = '{2'b00, 8'h10, 0, 0, 0, 8'h7D, 8'h83, 0, 0, 7'd4, 8'h82};
        tbl[19] = '{2'b00, 8'h10, 0, 0, 0, 8'h7D, 8'h83, 0, 0, 7'd4, 8'h82};
        tbl[20] = '{2'b00, 8'hFF, 0, 0, 0, 8'hEF, 8'h11, 0, 0, 7'd4, 8'h82};
        tbl[21] = '{2'b00, 8'hFF, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 7'd4, 8'h82};

        rst = 1'b1;
        drive(0, 2'b00, 8'h00, 0, 0, 0);
        drive(1, 2'b00, 8'h00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sarc",  ia.SAROutC, 8'hFF);
        chk("rst.sari_a", ia.SAROutI, 8'h01);
        chk("rst.sari_b", ib.SAROutI, 8'h04);
        chk("rst.sard",  ia.SAROutD, 8'h00);
        chk("rst.rdy",   ia.Ready, 1'b0);
        chk("rst.busy",  ia.Busy, 1'b0);
        chk("rst.tmr",   ia.TimerOut, 7'd0);
        chk("rst.dout",  ia.DataOut, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(0, tbl[i].statep, tbl[i].sarout, tbl[i].inc, tbl[i].dcr, tbl[i].ack);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d.sarc", i), ia.SAROutC, e.e_c);
            chk($sformatf("v%0d.sari", i), ia.SAROutI, e.e_i);
            chk($sformatf("v%0d.rdy", i),  ia.Ready, e.e_rdy);
            chk($sformatf("v%0d.busy", i), ia.Busy, e.e_busy);
            chk($sformatf("v%0d.tmr", i),  ia.TimerOut, e.e_tmr);
            chk($sformatf("v%0d.dout", i), ia.DataOut, e.e_dout);
        end

        // Ack arriving on the settle edge is ignored
        step(0, 2'b01, 8'h40, 0, 0, 0);
        repeat (3) step(0, 2'b01, 8'h40, 0, 0, 0);
        chk("coin.tmr3", ia.TimerOut, 7'd3);
        step(0, 2'b01, 8'h40, 0, 0, 1);
        chk("coin.rdy", ia.Ready, 1'b1);
        chk("coin.dout", ia.DataOut, 8'h40);
        chk("coin.busy", ia.Busy, 1'b0);
        step(0, 2'b01, 8'h40, 0, 0, 0);
        chk("coin.rdy_hold", ia.Ready, 1'b1);

        // Long HOLD at timer=2
        step(0, 2'b01, 8'h40, 0, 0, 1);
        chk("ack.rdy", ia.Ready, 1'b0);
        chk("ack.busy", ia.Busy, 1'b1);
        repeat (2) step(0, 2'b01, 8'h40, 0, 0, 0);
        chk("hold.pre_tmr", ia.TimerOut, 7'd2);
        for (int k = 0; k < 10; k++) begin
            step(0, 2'b10, 8'h40, 0, 0, 0);
            chk($sformatf("hold%0d.tmr", k), ia.TimerOut, 7'd2);
            chk($sformatf("hold%0d.rdy", k), ia.Ready, 1'b0);
        end
        step(0, 2'b01, 8'h40, 0, 0, 0);
        chk("resume.tmr", ia.TimerOut, 7'd3);
        chk("resume.rdy", ia.Ready, 1'b0);
        step(0, 2'b01, 8'h40, 0, 0, 0);
        chk("resume.rdy1", ia.Ready, 1'b1);
        chk("resume.tmr4", ia.TimerOut, 7'd4);
        chk("resume.dout", ia.DataOut, 8'h40);

        // Async reset in the middle of TRACK with code=0x55, timer=3
        step(0, 2'b00, 8'h55, 0, 0, 0);
        step(0, 2'b00, 8'h55, 0, 0, 0);
        step(0, 2'b01, 8'h55, 0, 0, 0);
        repeat (3) step(0, 2'b01, 8'h55, 0, 0, 0);
        chk("mid.tmr", ia.TimerOut, 7'd3);
        chk("mid.sarc", ia.SAROutC, 8'hAA);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.rdy",  ia.Ready, 1'b0);
        chk("arst.busy", ia.Busy, 1'b0);
        chk("arst.sarc", ia.SAROutC, 8'hFF);
        chk("arst.tmr",  ia.TimerOut, 7'd0);
        chk("arst.dout", ia.DataOut, 8'h00);
        chk("arst.sari", ia.SAROutI, 8'h01);
        @(negedge clk);
        drive(0, 2'b00, 8'h00, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post.sarc", ia.SAROutC, 8'hFF);
        chk("post.busy", ia.Busy, 1'b0);
        chk("post.sari", ia.SAROutI, 8'h01);

        // STEP=4 saturation at the top
        step(1, 2'b00, 8'hFD, 0, 0, 0);
        step(1, 2'b01, 8'hFD, 0, 0, 0);
        chk("b.sari_fd", ib.SAROutI, 8'hFF);
        step(1, 2'b01, 8'hFD, 1, 0, 0);
        chk("b.inc.tmr", ib.TimerOut, 7'd0);
        step(1, 2'b01, 8'hFD, 0, 0, 0);
        chk("b.top.sarc", ib.SAROutC, 8'h00);
        chk("b.top.sari", ib.SAROutI, 8'hFF);
        chk("b.top.tmr",  ib.TimerOut, 7'd1);
        step(1, 2'b01, 8'hFD, 1, 0, 0);
        chk("b.satinc.tmr", ib.TimerOut, 7'd0);
        step(1, 2'b01, 8'hFD, 0, 0, 0);
        chk("b.satinc.sarc", ib.SAROutC, 8'h00);

        // STEP=4 saturation at the bottom
        step(1, 2'b00, 8'h02, 0, 0, 0);
        step(1, 2'b00, 8'h02, 0, 0, 0);
        chk("b.sard_ff", ib.SAROutD, 8'hFB);
        step(1, 2'b01, 8'h02, 0, 0, 0);
        chk("b.sard_02", ib.SAROutD, 8'h00);
        chk("b.sari_02", ib.SAROutI, 8'h06);
        step(1, 2'b01, 8'h02, 0, 1, 0);
        chk("b.dcr.tmr", ib.TimerOut, 7'd0);
        step(1, 2'b01, 8'h02, 0, 0, 0);
        chk("b.bot.sarc", ib.SAROutC, 8'hFF);
        chk("b.bot.sard", ib.SAROutD, 8'h00);
        chk("b.bot.sari", ib.SAROutI, 8'h04);
        chk("b.bot.tmr",  ib.TimerOut, 7'd1);
        step(1, 2'b01, 8'h02, 0, 1, 0);
        chk("b.satdcr.tmr", ib.TimerOut, 7'd0);
        step(1, 2'b01, 8'h02, 0, 0, 0);
        chk("b.satdcr.sarc", ib.SAROutC, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
